// File: rtl/mem_arbiter_if.sv
// ============================================================================
//  Module      : mem_arbiter_if
//  Description : Bundle of cache-side and memory-side signals around the
//                unified main-memory arbiter.
//                slave  : arbiter view (takes cache requests and memory
//                         responses, drives done/rdata, mem_* and status).
//                master : environment view (caches + memory model).
//  Signals     : ic_req/ic_addr -> ic_done/ic_rdata          (I-cache, read)
//                dc_req/dc_wr/dc_addr/dc_wdata -> dc_done/dc_rdata (D-cache)
//                mem_req/mem_wr/mem_addr/mem_wdata -> mem_ack/mem_rdata
//                err (sticky timeout), busy (arbiter not idle)
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);
  logic              ic_req;
  logic [ADDR_W-1:0] ic_addr;
  logic              ic_done;
  logic [DATA_W-1:0] ic_rdata;

  logic              dc_req;
  logic              dc_wr;
  logic [ADDR_W-1:0] dc_addr;
  logic [DATA_W-1:0] dc_wdata;
  logic              dc_done;
  logic [DATA_W-1:0] dc_rdata;

  logic              mem_req;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              err;
  logic              busy;

  modport slave (
    input  ic_req, ic_addr, dc_req, dc_wr, dc_addr, dc_wdata, mem_ack, mem_rdata,
    output ic_done, ic_rdata, dc_done, dc_rdata,
    output mem_req, mem_wr, mem_addr, mem_wdata, err, busy
  );

  modport master (
    output ic_req, ic_addr, dc_req, dc_wr, dc_addr, dc_wdata, mem_ack, mem_rdata,
    input  ic_done, ic_rdata, dc_done, dc_rdata,
    input  mem_req, mem_wr, mem_addr, mem_wdata, err, busy
  );
endinterface

`default_nettype wire

// File: rtl/mem_arbiter.sv
// ============================================================================
//  Module      : mem_arbiter
//  Description : Shares one main-memory port between the I-cache miss path
//                (read only) and the D-cache miss/writeback path. One
//                transaction at a time: IDLE (grant) -> BUSY (mem_req held
//                until mem_ack or timeout) -> RESP (one-cycle done pulse).
//                A BUSY phase lasting TIMEOUT cycles without mem_ack sets the
//                sticky err flag and returns 16'hDEAD to the owner.
//  Ports       : clk  - system clock
//                rst  - synchronous, active-high reset
//                bus  - mem_arbiter_if.slave (cache, memory and status signals)
//  Parameters  : ADDR_W, DATA_W, TIMEOUT (>= 2)
//  Build macro : MEM_ARB_RR_EN - round-robin on simultaneous requests;
//                undefined gives fixed priority (D-cache wins).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus
);

  localparam int                CNT_W      = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0]  C_CNT_LAST = CNT_W'(TIMEOUT - 1);
  localparam logic [DATA_W-1:0] C_ERR_DATA = DATA_W'(16'hDEAD);
  localparam logic              C_OWN_IC   = 1'b0;
  localparam logic              C_OWN_DC   = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic              r_owner;
  logic              r_last_grant;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_err;
  logic              r_mem_wr;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic [DATA_W-1:0] r_ic_rdata;
  logic [DATA_W-1:0] r_dc_rdata;

  logic              w_any_req;
  logic              w_tie_dc;
  logic              w_pick_dc;
  logic              w_capture;
  logic              w_timeout;
  logic [DATA_W-1:0] w_resp_data;

  assign w_any_req = bus.ic_req | bus.dc_req;

  // Winner of a simultaneous request.
`ifdef MEM_ARB_RR_EN
  assign w_tie_dc = (r_last_grant == C_OWN_IC);
`else
  // last_grant is tracked in both builds; fixed priority always favours dc.
  assign w_tie_dc = 1'b1 | r_last_grant;
`endif

  assign w_pick_dc = bus.dc_req & (~bus.ic_req | w_tie_dc);

  // BUSY ends on mem_ack, or on the last allowed cycle; ack wins a tie.
  assign w_capture   = (r_state == S_BUSY) & (bus.mem_ack | (r_cnt == C_CNT_LAST));
  assign w_timeout   = (r_state == S_BUSY) & ~bus.mem_ack & (r_cnt == C_CNT_LAST);
  assign w_resp_data = bus.mem_ack ? (r_mem_wr ? '0 : bus.mem_rdata) : C_ERR_DATA;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_any_req) w_state_nxt = S_BUSY;
      S_BUSY:  if (w_capture) w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner      <= C_OWN_IC;
      r_last_grant <= C_OWN_IC;
      r_cnt        <= '0;
      r_err        <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_ic_rdata   <= '0;
      r_dc_rdata   <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            r_owner     <= w_pick_dc ? C_OWN_DC : C_OWN_IC;
            r_mem_addr  <= w_pick_dc ? bus.dc_addr : bus.ic_addr;
            r_mem_wr    <= w_pick_dc & bus.dc_wr;
            r_mem_wdata <= w_pick_dc ? bus.dc_wdata : '0;
          end
        end
        S_BUSY: begin
          r_cnt <= r_cnt + CNT_W'(1);
          // Per-requester capture registers double as the held rdata outputs.
          if (w_capture) begin
            if (r_owner == C_OWN_DC) begin
              r_dc_rdata <= w_resp_data;
            end else begin
              r_ic_rdata <= w_resp_data;
            end
          end
          if (w_timeout) begin
            r_err <= 1'b1;
          end
        end
        S_RESP: begin
          r_cnt        <= '0;
          r_last_grant <= r_owner;
        end
        default: ;
      endcase
    end
  end

  assign bus.mem_req   = (r_state == S_BUSY);
  assign bus.mem_wr    = r_mem_wr;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.ic_done   = (r_state == S_RESP) & (r_owner == C_OWN_IC);
  assign bus.dc_done   = (r_state == S_RESP) & (r_owner == C_OWN_DC);
  assign bus.ic_rdata  = r_ic_rdata;
  assign bus.dc_rdata  = r_dc_rdata;
  assign bus.err       = r_err;
  assign bus.busy      = (r_state != S_IDLE);

endmodule

`default_nettype wire
